mdu_ctrl: RTL and testbench

- Multiply/divide sequencer for the five-stage MIPS pipeline. Sits in the E stage beside the ALU and owns the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo from E and runs a fixed-latency busy countdown that models the multi-cycle unit.
- Provides mfhi/mflo read data to the E-stage result mux.
- Raises a stall request that freezes the D stage while an HI/LO-class instruction would conflict.

---
 rtl/mdu_ctrl.sv | 127 ++++++++++++
 tb/tb_mdu_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models unit latency
// with a busy countdown, and stalls D while an HI/LO-class op would conflict.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDUop_E,
  input  logic [1:0]  MDUread_E,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MDinst_D,
  output logic        Start,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUout
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CLOG_W     = $clog2(MAX_CYCLES + 1);
  localparam int unsigned CW         = (CLOG_W < 4) ? 4 : CLOG_W;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdu_op_e;

  mdu_op_e op;
  assign op = mdu_op_e'(MDUop_E);

  logic [CW-1:0] count_q, count_n;
  logic [31:0]   hi_q, hi_n, lo_q, lo_n;
  logic [31:0]   pend_hi_q, pend_hi_n, pend_lo_q, pend_lo_n;

  // Result datapath; divisors forced non-zero so the divider never sees 0
  logic [63:0] sprod, uprod;
  logic [31:0] a_mag, b_mag, b_mag_nz, b_nz;
  logic [31:0] sq_mag, sr_mag, sq, sr, uq, ur;
  logic [63:0] result;

  always_comb begin
    sprod    = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    uprod    = {32'd0, A} * {32'd0, B};
    a_mag    = A[31] ? (~A + 32'd1) : A;
    b_mag    = B[31] ? (~B + 32'd1) : B;
    b_mag_nz = (b_mag == 32'd0) ? 32'd1 : b_mag;
    b_nz     = (B == 32'd0) ? 32'd1 : B;
    sq_mag   = a_mag / b_mag_nz;
    sr_mag   = a_mag % b_mag_nz;
    sq       = (A[31] ^ B[31]) ? (~sq_mag + 32'd1) : sq_mag;
    sr       = A[31] ? (~sr_mag + 32'd1) : sr_mag;
    uq       = A / b_nz;
    ur       = A % b_nz;
    case (op)
      OP_MULT:  result = sprod;
      OP_MULTU: result = uprod;
      OP_DIV:   result = (B == 32'd0) ? {hi_q, lo_q} : {sr, sq};
      OP_DIVU:  result = (B == 32'd0) ? {hi_q, lo_q} : {ur, uq};
      default:  result = {hi_q, lo_q};
    endcase
  end

  assign Start = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign Stall = MDinst_D & (Start | Busy);

  always_comb begin
    case (MDUread_E)
      2'b01:   MDUout = hi_q;
      2'b10:   MDUout = lo_q;
      default: MDUout = 32'd0;
    endcase
  end

  // Next state: countdown with write-back on the last busy edge, else accept/move-to
  always_comb begin
    count_n   = count_q;
    hi_n      = hi_q;
    lo_n      = lo_q;
    pend_hi_n = pend_hi_q;
    pend_lo_n = pend_lo_q;
    if (count_q != CW'(0)) begin
      count_n = count_q - CW'(1);
      if (count_q == CW'(1)) begin
        hi_n = pend_hi_q;
        lo_n = pend_lo_q;
      end
    end else if (Start) begin
      pend_hi_n = result[63:32];
      pend_lo_n = result[31:0];
      count_n   = ((op == OP_MULT) || (op == OP_MULTU)) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (op == OP_MTHI) begin
      hi_n = A;
    end else if (op == OP_MTLO) begin
      lo_n = A;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      count_q   <= count_n;
      hi_q      <= hi_n;
      lo_q      <= lo_n;
      pend_hi_q <= pend_hi_n;
      pend_lo_q <= pend_lo_n;
    end
  end

  assign Busy = (count_q != CW'(0));
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases with literal expectations
// plus randomized traffic against an absolute-cycle behavioural model.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  MDUop_E;
  logic [1:0]  MDUread_E;
  logic [31:0] A, B;
  logic        MDinst_D;
  logic        Start, Busy, Stall;
  logic [31:0] HI, LO, MDUout;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .MDUop_E(MDUop_E), .MDUread_E(MDUread_E),
    .A(A), .B(B), .MDinst_D(MDinst_D), .Start(Start), .Busy(Busy),
    .Stall(Stall), .HI(HI), .LO(LO), .MDUout(MDUout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: busy through cycle busy_until; write-back at the edge ending it
  int          cyc        = 0;
  int          busy_until = -1;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'd1: return 64'(sa * sb);
      3'd2: return 64'(ua * ub);
      3'd3: begin
        if (b == 0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 0) return {hi, lo};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return {hi, lo};
    endcase
  endfunction

  task automatic compare_outputs();
    logic        e_start, e_busy;
    logic [31:0] e_out;
    e_start = (MDUop_E >= 3'd1) && (MDUop_E <= 3'd4);
    e_busy  = (cyc <= busy_until);
    e_out   = (MDUread_E == 2'b01) ? m_hi : (MDUread_E == 2'b10) ? m_lo : 32'd0;
    chk("start",  32'(Start), 32'(e_start));
    chk("busy",   32'(Busy),  32'(e_busy));
    chk("stall",  32'(Stall), 32'(MDinst_D & (e_start | e_busy)));
    chk("hi",     HI,  m_hi);
    chk("lo",     LO,  m_lo);
    chk("mduout", MDUout, e_out);
  endtask

  task automatic model_edge(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (cyc <= busy_until) begin
      if (cyc == busy_until) {m_hi, m_lo} = m_pend;
    end else if (op >= 3'd1 && op <= 3'd4) begin
      m_pend     = ref_result(op, a, b, m_hi, m_lo);
      busy_until = cyc + ((op <= 3'd2) ? MULT_N : DIV_N);
    end else if (op == 3'd5) begin
      m_hi = a;
    end else if (op == 3'd6) begin
      m_lo = a;
    end
  endtask

  task automatic step(input logic [2:0] op, input logic [1:0] rd, input logic [31:0] a,
                      input logic [31:0] b, input logic md);
    @(negedge clk);
    MDUop_E = op; MDUread_E = rd; A = a; B = b; MDinst_D = md;
    #1 compare_outputs();
    @(posedge clk);
    model_edge(op, a, b);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'd0, 2'(i % 3), 32'd0, 32'd0, 1'b1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    MDUop_E = 3'd0; MDUread_E = 2'b01; MDinst_D = 1'b1;
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    busy_until = -1; m_hi = '0; m_lo = '0; m_pend = '0;
    repeat (2) begin @(posedge clk); cyc++; end
    @(negedge clk) reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; MDUop_E = '0; MDUread_E = '0; A = '0; B = '0; MDinst_D = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Idle after reset
    step(3'd0, 2'b01, 32'd0, 32'd0, 1'b1);
    step(3'd0, 2'b10, 32'd0, 32'd0, 1'b1);
    #2 chk("idle_mduout", MDUout, 32'd0);
    chk("idle_stall", 32'(Stall), 32'd0);

    // mult -2 * 3
    step(3'd1, 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1);
    #2 chk("mult_busy", 32'(Busy), 32'd1);
    chk("mult_stall", 32'(Stall), 32'd1);
    idle(MULT_N);
    #2 chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);
    chk("mult_done_stall", 32'(Stall), 32'd0);

    // multu same operands
    step(3'd2, 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1);
    idle(MULT_N);
    #2 chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);

    // div -7 / 2
    step(3'd3, 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1);
    idle(DIV_N - 1);
    #2 chk("div_still_busy", 32'(Busy), 32'd1);
    idle(1);
    #2 chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    // divu 7 / 2
    step(3'd4, 2'b00, 32'd7, 32'd2, 1'b0);
    idle(DIV_N);
    #2 chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    // Signed overflow case
    step(3'd3, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    idle(DIV_N);
    #2 chk("ovf_lo", LO, 32'h8000_0000);
    chk("ovf_hi", HI, 32'd0);

    // Divide by zero keeps HI/LO
    step(3'd5, 2'b00, 32'h11, 32'd0, 1'b1);
    step(3'd6, 2'b01, 32'h22, 32'd0, 1'b1);
    #2 chk("mthi_read", MDUout, 32'h11);
    step(3'd3, 2'b00, 32'd5, 32'd0, 1'b1);
    idle(DIV_N);
    #2 chk("dbz_hi", HI, 32'h11);
    chk("dbz_lo", LO, 32'h22);

    // Start and mtlo while busy are ignored
    step(3'd1, 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1);
    step(3'd0, 2'b00, 32'd0, 32'd0, 1'b1);
    step(3'd1, 2'b00, 32'd7, 32'd7, 1'b1);
    step(3'd6, 2'b00, 32'hDEAD, 32'd0, 1'b1);
    idle(2);
    #2 chk("ign_hi", HI, 32'hFFFF_FFFF);
    chk("ign_lo", LO, 32'hFFFF_FFFA);
    chk("ign_busy", 32'(Busy), 32'd0);

    // Reset in cycle 3 of a div
    step(3'd3, 2'b00, 32'd100, 32'd7, 1'b1);
    idle(2);
    apply_reset();
    idle(DIV_N + 2);
    #2 chk("rst_no_wb_hi", HI, 32'd0);
    chk("rst_no_wb_lo", LO, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 15))
        0, 1:    b = 32'd0;
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3:       b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      step(op, 2'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)));
    end
    idle(DIV_N + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
